// File: rtl/bfp_converter_shared_exponent.sv
// rtl/bfp_converter_shared_exponent.sv - pipelined shared-exponent finder with per-lane shift (optional BFP_SHIFT_SAT_EN saturation)
module bfp_converter_shared_exponent #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int LANES          = 8,
    parameter int SHIFT_WIDTH    = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*EXPONENT_WIDTH-1:0] in_exponent,
    input  logic [LANES-1:0]                in_mask,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXPONENT_WIDTH-1:0]       out_exponent,
    output logic [LANES*SHIFT_WIDTH-1:0]    out_shift,
    output logic [LANES-1:0]                out_zero,
    output logic [LANES-1:0]                out_sat
);

    localparam int EW = EXPONENT_WIDTH;
    localparam int SW = SHIFT_WIDTH;
    localparam int L  = $clog2(LANES);

    localparam logic [EW-1:0] EXP_MIN   = {1'b1, {(EW-1){1'b0}}};
    localparam logic [SW-1:0] SHIFT_ALL = '1;

    // One global enable: the whole pipeline moves or the whole pipeline holds.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Stage 0..L sideband: valid bit, raw exponents and mask follow the tree.
    logic [L:0]              valid_q;
    logic [LANES*EW-1:0]     exp_q  [0:L];
    logic [LANES-1:0]        mask_q [0:L];

    // Comparison tree stored heap-style: node n has children 2n and 2n+1,
    // leaves live at LANES..2*LANES-1, node 1 is the root (shared exponent).
    logic [EW-1:0]           node_q [1:LANES-1];
    logic [EW-1:0]           child  [2:2*LANES-1];

    logic [EW:0]             root_ext;
    logic [LANES*SW-1:0]     shift_c;

    // Advance valid bits and the raw-lane sideband one stage per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int j = 0; j <= L; j++) begin
                exp_q[j]  <= '0;
                mask_q[j] <= '0;
            end
        end else if (adv) begin
            valid_q[0] <= in_valid;
            exp_q[0]   <= in_exponent;
            mask_q[0]  <= in_mask;
            for (int j = 1; j <= L; j++) begin
                valid_q[j] <= valid_q[j-1];
                exp_q[j]   <= exp_q[j-1];
                mask_q[j]  <= mask_q[j-1];
            end
        end
    end

    // Tree inputs: internal nodes from registers, leaves from stage 0 with
    // masked lanes forced to the most negative exponent.
    always_comb begin
        for (int n = 2; n < LANES; n++) begin
            child[n] = node_q[n];
        end
        for (int k = 0; k < LANES; k++) begin
            child[LANES+k] = mask_q[0][k] ? EXP_MIN : exp_q[0][k*EW +: EW];
        end
    end

    // Registered pairwise signed max; ties keep the lower-index child.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 1; n < LANES; n++) begin
                node_q[n] <= '0;
            end
        end else if (adv) begin
            for (int n = 1; n < LANES; n++) begin
                node_q[n] <= ($signed(child[2*n+1]) > $signed(child[2*n])) ? child[2*n+1] : child[2*n];
            end
        end
    end

    assign root_ext = {node_q[1][EW-1], node_q[1]};

`ifdef BFP_SHIFT_SAT_EN
    localparam logic [EW:0] SHIFT_MAX = (EW+1)'({SW{1'b1}});

    logic [EW:0]             diff_c [LANES];
    logic [LANES-1:0]        sat_c;

    // Full-width difference max - e, never negative, needed for the range check.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            diff_c[i] = root_ext - {exp_q[L][i*EW+EW-1], exp_q[L][i*EW +: EW]};
        end
    end

    // Per-lane shift with clamp to the largest representable shift.
    always_comb begin
        shift_c = '0;
        sat_c   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mask_q[L][i]) begin
                shift_c[i*SW +: SW] = SHIFT_ALL;
            end else if (diff_c[i] > SHIFT_MAX) begin
                shift_c[i*SW +: SW] = SHIFT_ALL;
                sat_c[i]            = 1'b1;
            end else begin
                shift_c[i*SW +: SW] = diff_c[i][SW-1:0];
            end
        end
    end

    // Saturation flags are registered alongside the rest of the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat <= '0;
        end else if (adv && valid_q[L]) begin
            out_sat <= sat_c;
        end
    end
`else
    // Per-lane shift as the low bits of max - e; the caller keeps it in range.
    always_comb begin
        shift_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mask_q[L][i]) begin
                shift_c[i*SW +: SW] = SHIFT_ALL;
            end else begin
                shift_c[i*SW +: SW] = SW'(root_ext - {exp_q[L][i*EW+EW-1], exp_q[L][i*EW +: EW]});
            end
        end
    end

    assign out_sat = '0;
`endif

    // Output stage: load only on advance with a valid beat, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_exponent <= '0;
            out_shift    <= '0;
            out_zero     <= '0;
        end else if (adv) begin
            out_valid <= valid_q[L];
            if (valid_q[L]) begin
                out_exponent <= node_q[1];
                out_shift    <= shift_c;
                out_zero     <= mask_q[L];
            end
        end
    end

endmodule

// File: tb/tb_bfp_converter_shared_exponent.sv
// tb/tb_bfp_converter_shared_exponent.sv - self-checking bench for bfp_converter_shared_exponent
module tb_bfp_converter_shared_exponent;

    localparam int EW    = 8;
    localparam int LANES = 8;
    localparam int SW    = 5;
    localparam int D     = $clog2(LANES) + 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [LANES*EW-1:0]   in_exponent = '0;
    logic [LANES-1:0]      in_mask = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [EW-1:0]         out_exponent;
    logic [LANES*SW-1:0]   out_shift;
    logic [LANES-1:0]      out_zero;
    logic [LANES-1:0]      out_sat;

    typedef struct packed {
        logic [EW-1:0]       e;
        logic [LANES*SW-1:0] sh;
        logic [LANES-1:0]    z;
        logic [LANES-1:0]    s;
    } res_t;

    int   checks = 0;
    int   failures = 0;
    res_t sb[$];

    bfp_converter_shared_exponent #(
        .EXPONENT_WIDTH(EW),
        .LANES(LANES),
        .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_exponent(in_exponent),
        .in_mask(in_mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_exponent(out_exponent),
        .out_shift(out_shift),
        .out_zero(out_zero),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // Reference: maximum over unmasked lanes, then shift = max - e per lane.
    function automatic res_t model(input logic [LANES*EW-1:0] ex, input logic [LANES-1:0] m);
        res_t r;
        int   mx;
        int   e;
        int   d;
        int   lim;
        r   = '0;
        lim = (1 << SW) - 1;
        mx  = -(1 << (EW - 1));
        for (int i = 0; i < LANES; i++) begin
            e = int'($signed(ex[i*EW +: EW]));
            if (!m[i] && e > mx) mx = e;
        end
        r.e = EW'(mx);
        for (int i = 0; i < LANES; i++) begin
            e = int'($signed(ex[i*EW +: EW]));
            d = mx - e;
            if (m[i]) begin
                r.sh[i*SW +: SW] = SW'(lim);
                r.z[i] = 1'b1;
            end else begin
`ifdef BFP_SHIFT_SAT_EN
                if (d > lim) begin
                    r.sh[i*SW +: SW] = SW'(lim);
                    r.s[i] = 1'b1;
                end else begin
                    r.sh[i*SW +: SW] = SW'(d);
                end
`else
                r.sh[i*SW +: SW] = SW'(d % (lim + 1));
`endif
            end
        end
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.e  = out_exponent;
        r.sh = out_shift;
        r.z  = out_zero;
        r.s  = out_sat;
        return r;
    endfunction

    function automatic logic [LANES*EW-1:0] pack_vals(input int v[LANES]);
        logic [LANES*EW-1:0] x;
        for (int i = 0; i < LANES; i++) x[i*EW +: EW] = EW'(v[i]);
        return x;
    endfunction

    function automatic logic [LANES*EW-1:0] rand_exps();
        logic [LANES*EW-1:0] x;
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 1) == 0) x[i*EW +: EW] = EW'($urandom_range(0, 8) - 4);
            else                           x[i*EW +: EW] = EW'($urandom);
        end
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one beat into an idle pipeline and wait for its result.
    task automatic run_single(input logic [LANES*EW-1:0] ex, input logic [LANES-1:0] m,
                              output res_t got, output int lat);
        in_exponent = ex;
        in_mask     = m;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        got = observed();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_exponent !== '0) begin failures++; $display("FAIL reset_out_exponent got=%h want=0", out_exponent); end
        checks++; if (out_shift !== '0) begin failures++; $display("FAIL reset_out_shift got=%h want=0", out_shift); end
        checks++; if (out_zero !== '0) begin failures++; $display("FAIL reset_out_zero got=%h want=0", out_zero); end
        checks++; if (out_sat !== '0) begin failures++; $display("FAIL reset_out_sat got=%h want=0", out_sat); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        int   v[LANES] = '{3, -2, 7, 7, 0, -128, 5, 1};
        int   sh[LANES];
        logic [LANES*SW-1:0] want_sh;
        logic [LANES-1:0]    want_sat;
        res_t got;
        int   lat;
`ifdef BFP_SHIFT_SAT_EN
        sh = '{4, 9, 0, 0, 7, 31, 2, 6};
        want_sat = 8'b0010_0000;
`else
        sh = '{4, 9, 0, 0, 7, 7, 2, 6};
        want_sat = 8'b0000_0000;
`endif
        for (int i = 0; i < LANES; i++) want_sh[i*SW +: SW] = SW'(sh[i]);
        run_single(pack_vals(v), '0, got, lat);
        checks++; if (lat !== D) begin failures++; $display("FAIL directed_latency got=%0d want=%0d", lat, D); end
        checks++; if (got.e !== 8'd7) begin failures++; $display("FAIL directed_exponent got=%0d want=7", $signed(got.e)); end
        checks++; if (got.sh !== want_sh) begin failures++; $display("FAIL directed_shift got=%h want=%h", got.sh, want_sh); end
        checks++; if (got.z !== '0) begin failures++; $display("FAIL directed_zero got=%b want=0", got.z); end
        checks++; if (got.s !== want_sat) begin failures++; $display("FAIL directed_sat got=%b want=%b", got.s, want_sat); end
    endtask

    task automatic test_mask();
        int   v[LANES] = '{10, 20, -3, 4, 15, 0, -50, 12};
        res_t got;
        res_t want;
        int   lat;
        run_single(pack_vals(v), 8'h02, got, lat);
        want = model(pack_vals(v), 8'h02);
        checks++; if (got.e !== 8'd15) begin failures++; $display("FAIL mask_exponent got=%0d want=15", $signed(got.e)); end
        checks++; if (got.sh[1*SW +: SW] !== 5'd31) begin failures++; $display("FAIL mask_lane1_shift got=%0d want=31", got.sh[1*SW +: SW]); end
        checks++; if (got.z !== 8'h02) begin failures++; $display("FAIL mask_zero got=%b want=00000010", got.z); end
        checks++; if (got !== want) begin failures++; $display("FAIL mask_model got=%h want=%h", got, want); end
        run_single(pack_vals(v), 8'hFF, got, lat);
        checks++; if (got.e !== 8'h80) begin failures++; $display("FAIL allmask_exponent got=%0d want=-128", $signed(got.e)); end
        checks++; if (got.z !== 8'hFF) begin failures++; $display("FAIL allmask_zero got=%b want=11111111", got.z); end
        checks++; if (got.sh !== '1 || got.s !== '0) begin failures++; $display("FAIL allmask_shift got=%h/%b want=all ones/0", got.sh, got.s); end
    endtask

    task automatic test_random_single();
        logic [LANES*EW-1:0] ex;
        logic [LANES-1:0]    m;
        res_t got;
        res_t want;
        int   lat;
        for (int t = 0; t < 6; t++) begin
            ex = rand_exps();
            m  = LANES'($urandom) & LANES'($urandom);
            want = model(ex, m);
            run_single(ex, m, got, lat);
            checks++; if (lat !== D) begin failures++; $display("FAIL single%0d_latency got=%0d want=%0d", t, lat, D); end
            checks++; if (got !== want) begin failures++; $display("FAIL single%0d_result got=%h want=%h", t, got, want); end
        end
    endtask

    task automatic test_stream();
        int   sent = 0;
        int   recv = 0;
        int   cyc = 0;
        int   extra = 0;
        logic holding = 1'b0;
        res_t held;
        res_t want;
        sb.delete();
        while (recv < 20 && cyc < 2000) begin
            in_valid    = (sent < 20) ? ($urandom_range(0, 3) != 0) : 1'b0;
            in_exponent = rand_exps();
            in_mask     = LANES'($urandom) & LANES'($urandom) & LANES'($urandom);
            out_ready   = $urandom_range(0, 1);
            #1;
            if (holding) begin
                checks++;
                if (!out_valid || observed() !== held) begin
                    failures++;
                    $display("FAIL stream_stable valid=%b got=%h want=%h", out_valid, observed(), held);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_exponent, in_mask));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra_beat got=%h want=none", observed());
                end else begin
                    want = sb.pop_front();
                    if (observed() !== want) begin
                        failures++;
                        $display("FAIL stream_beat%0d got=%h want=%h", recv, observed(), want);
                    end
                end
                recv++;
            end
            holding = out_valid && !out_ready;
            held    = observed();
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (recv !== 20 || sb.size() != 0) begin failures++; $display("FAIL stream_count got=%0d want=20 pending=%0d", recv, sb.size()); end
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid) extra++;
            step();
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL stream_dup got=%0d want=0", extra); end
    endtask

    task automatic test_back_to_back();
        int   recv = 0;
        int   first = -1;
        int   last = -1;
        int   notready = 0;
        res_t want;
        sb.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 60 && recv < 12; c++) begin
            in_valid    = (c < 12);
            in_exponent = rand_exps();
            in_mask     = LANES'($urandom) & LANES'($urandom);
            #1;
            if (in_valid && !in_ready) notready++;
            if (in_valid && in_ready) sb.push_back(model(in_exponent, in_mask));
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
                checks++;
                want = (sb.size() != 0) ? sb.pop_front() : '0;
                if (observed() !== want) begin
                    failures++;
                    $display("FAIL b2b_beat%0d got=%h want=%h", recv, observed(), want);
                end
                recv++;
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (notready !== 0) begin failures++; $display("FAIL b2b_in_ready low_cycles=%0d want=0", notready); end
        checks++; if (first !== D) begin failures++; $display("FAIL b2b_fill got=%0d want=%0d", first, D); end
        checks++; if (recv !== 12 || last - first !== 11) begin failures++; $display("FAIL b2b_rate got=%0d beats in %0d cycles want=12 in 12", recv, last - first + 1); end
    endtask

    task automatic test_reset_midstream();
        int wait_cyc = 0;
        int stale = 0;
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid    = 1'b1;
            in_exponent = rand_exps();
            in_mask     = '0;
            #1;
            step();
        end
        in_valid = 1'b0;
        while (!out_valid && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_fill got=%b want=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin failures++; $display("FAIL midrst_stale got=%0d want=0", stale); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_mask();
        test_random_single();
        test_stream();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
